cordic_rr_scheduler: RTL and testbench
======================================

// Module: cordic_rr_scheduler
// PURPOSE
//   Shares one iterative CORDIC cosine unit (start/angle -> cos_out/done) between
//   NUM_REQ requesters using round-robin arbitration.
//   Accepts one request, pulses the unit's start, waits for done with a watchdog,
//   then returns the result tagged with the requester id. Only one job is in flight.
//   Sits between the per-channel FP front ends and the single CORDIC instance.
// PARAMETERS
//   NUM_REQ  4   number of requesters (>=2, power of two)
//   DATA_W   22  angle/cos width, signed fixed point, 20 fraction bits (22'h080000 = 0.5)
//   TIMEOUT  64  max cycles in WAIT before the job is aborted with rsp_err
// PORTS
//   clk           in   1                  clock, all logic on posedge
//   reset         in   1                  synchronous, active-low reset
//   req_valid     in   NUM_REQ            per-requester request valid
//   req_angle     in   NUM_REQ*DATA_W     angles; requester i = bits [i*DATA_W +: DATA_W]
//   req_ready     out  NUM_REQ            one-hot accept strobe
//   rsp_valid     out  1                  response valid
//   rsp_ready     in   1                  response consumer ready
//   rsp_id        out  log2(NUM_REQ)      requester index of response
//   rsp_cos       out  DATA_W             cosine result (0 when rsp_err)
//   rsp_err       out  1                  1 = watchdog timeout, no result
//   cordic_start  out  1                  one-cycle start pulse to CORDIC unit
//   cordic_angle  out  DATA_W             angle to CORDIC unit
//   cordic_cos    in   DATA_W             CORDIC result
//   cordic_done   in   1                  CORDIC completion pulse
//   busy          out  1                  high in any state except IDLE
// BEHAVIOUR
//   Reset (reset==0 at posedge): state=IDLE; rr pointer=0; timer=0; all outputs 0.
//     Reset mid-job drops the job silently; later cordic_done is ignored.
//   FSM: IDLE -> START -> WAIT -> RESP -> IDLE.
//   IDLE: if any req_valid, winner w = first set bit scanning ptr, ptr+1, ... mod NUM_REQ.
//     req_ready[w]=1 combinationally in that cycle; the transfer happens on that edge.
//     Angle and id are latched into regs; next state is START.
//     Requesters hold valid and angle until they see ready. No ready outside IDLE.
//   START: cordic_start=1 for exactly this cycle; timer<=0; -> WAIT.
//     cordic_done is ignored in START.
//   WAIT: timer increments each cycle.
//     cordic_done=1: rsp_cos<=cordic_cos, rsp_err<=0, -> RESP.
//     Else if timer==TIMEOUT-1: rsp_cos<=0, rsp_err<=1, -> RESP.
//     done and timeout in the same cycle: done wins.
//   cordic_angle = latched angle, stable from START until WAIT exits.
//     Requester input changes after acceptance have no effect.
//   RESP: rsp_valid=1, with rsp_id/rsp_cos/rsp_err held stable.
//     When rsp_ready=1: ptr<=(id+1) mod NUM_REQ; -> IDLE. Pointer also advances on error.
//     rsp_ready low stalls indefinitely; no new acceptance while stalled.
//   Latency: accept at edge T; cordic_start high in cycle T+1; done at cycle D;
//     rsp_valid from D+1. Timeout: rsp_valid rises TIMEOUT+1 cycles after cordic_start.
//   Throughput: one job per (CORDIC latency + 3) cycles minimum.
// TESTING
//   1 single: req_valid[0], angle 22'h080000; stub done 40 cyc after start, cos 22'h0E0A94
//     -> one start pulse; rsp id=0, cos=22'h0E0A94, err=0.
//   2 fairness: all 4 valid after reset -> served 0,1,2,3; then reqs 1 and 3 valid
//     -> served 1 then 3.
//   3 timeout: stub never asserts done -> rsp_valid TIMEOUT+1=65 cyc after start, err=1, cos=0;
//     next request is served normally.
//   4 backpressure: rsp_ready low 10 cyc with req 2 pending -> rsp fields stable,
//     req_ready=0, no cordic_start.
//   5 reset mid-WAIT: reset low 1 cyc -> all outputs 0; late cordic_done yields no rsp_valid.
//   6 stability: accept 22'h100000, requester changes angle -> cordic_angle stays 22'h100000
//     through WAIT.

Source files
------------

// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end that shares one iterative CORDIC cosine unit
// between NUM_REQ requesters, with a done watchdog. One job in flight.
module cordic_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 22,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_angle,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [DATA_W-1:0]            rsp_cos,
    output logic                         rsp_err,
    output logic                         cordic_start,
    output logic [DATA_W-1:0]            cordic_angle,
    input  logic [DATA_W-1:0]            cordic_cos,
    input  logic                         cordic_done,
    output logic                         busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     id_q;
    logic [TMR_W-1:0]    timer_q;
    logic [DATA_W-1:0]   angle_q;
    logic [DATA_W-1:0]   cos_q;
    logic                err_q;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic [ID_W-1:0]     scan_idx;
    logic [DATA_W-1:0]   win_angle;
    logic                timeout_hit;

    // Scan from the pointer upward; ID_W-bit wrap gives the modulo.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        scan_idx  = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ptr_q + ID_W'(k);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign win_angle   = req_angle[win_idx*DATA_W +: DATA_W];
    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (cordic_done || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready is suppressed while reset is low so no transfer is claimed.
    always_comb begin
        req_ready    = '0;
        cordic_start = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (reset && win_found) begin
                    req_ready[win_idx] = 1'b1;
                end
            end
            START: begin
                cordic_start = 1'b1;
            end
            WAIT: begin
                busy = 1'b1;
            end
            RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q   <= '0;
            id_q    <= '0;
            timer_q <= '0;
            angle_q <= '0;
            cos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_found) begin
                        id_q    <= win_idx;
                        angle_q <= win_angle;
                    end
                end
                START: begin
                    timer_q <= '0;
                end
                WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    if (cordic_done) begin
                        cos_q <= cordic_cos;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        cos_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        ptr_q <= id_q + 1'b1;
                    end
                end
                default: begin
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign rsp_id       = id_q;
    assign rsp_cos      = cos_q;
    assign rsp_err      = err_q;
    assign cordic_angle = angle_q;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Directed bench for cordic_rr_scheduler with a behavioural CORDIC stub
// whose latency, result and done enable are set per step.
module tb_cordic_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 22;
    localparam int TIMEOUT = 64;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_angle;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [1:0]                rsp_id;
    logic [DATA_W-1:0]         rsp_cos;
    logic                      rsp_err;
    logic                      cordic_start;
    logic [DATA_W-1:0]         cordic_angle;
    logic [DATA_W-1:0]         cordic_cos = '0;
    logic                      cordic_done = 1'b0;
    logic                      busy;

    int tests = 0;
    int fails = 0;

    int                stub_lat = 0;
    logic              stub_en  = 1'b1;
    logic [DATA_W-1:0] stub_cos = '0;
    int                stub_cnt = 0;
    int                n_starts = 0;

    always #5 clk = ~clk;

    cordic_rr_scheduler #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_angle   (req_angle),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_cos     (rsp_cos),
        .rsp_err     (rsp_err),
        .cordic_start(cordic_start),
        .cordic_angle(cordic_angle),
        .cordic_cos  (cordic_cos),
        .cordic_done (cordic_done),
        .busy        (busy)
    );

    // Stub: done is high in cycle start+stub_lat; cos is junk otherwise.
    always @(negedge clk) begin
        cordic_done = 1'b0;
        cordic_cos  = 22'h2AAAAA;
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0 && stub_en) begin
                cordic_done = 1'b1;
                cordic_cos  = stub_cos;
            end
        end
        if (cordic_start === 1'b1) begin
            stub_cnt = stub_lat;
            n_starts++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_angle(input int i, input logic [DATA_W-1:0] a);
        req_angle[i*DATA_W +: DATA_W] = a;
    endtask

    task automatic accept(output logic [NUM_REQ-1:0] rdy);
        #1;
        rdy = req_ready;
        step();
        req_valid = req_valid & ~rdy;
        chk("start_pulse", {cordic_start, busy}, 2'b11);
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        chk("rsp_seen", rsp_valid, 1'b1);
    endtask

    logic [NUM_REQ-1:0] rdy;
    logic [NUM_REQ-1:0] exp_rdy;
    int                 cyc;
    int                 starts0;
    int                 n_rv;

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_angle = '0;
        rsp_ready = 1'b1;
        repeat (3) step();
        chk("reset_outs", {req_ready, rsp_valid, rsp_id, rsp_cos, rsp_err,
                           cordic_start, cordic_angle, busy}, '0);
        reset = 1'b1;
        step();
        chk("idle_no_req", {req_ready, busy}, '0);

        // single job
        stub_lat = 40;
        stub_cos = 22'h0E0A94;
        starts0  = n_starts;
        set_angle(0, 22'h080000);
        req_valid = 4'b0001;
        accept(rdy);
        chk("t1_ready", rdy, 4'b0001);
        chk("t1_angle", cordic_angle, 22'h080000);
        wait_rsp(cyc);
        chk("t1_latency", cyc, 41);
        chk("t1_rsp", {rsp_id, rsp_cos, rsp_err}, {2'd0, 22'h0E0A94, 1'b0});
        chk("t1_starts", n_starts - starts0, 1);
        step();
        chk("t1_idle", {busy, rsp_valid}, 2'b00);

        // fairness from reset
        reset = 1'b0;
        step();
        reset    = 1'b1;
        stub_lat = 3;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_angle(i, DATA_W'(22'h010000 * (i + 1)));
        end
        req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) begin
            exp_rdy = 4'(1 << i);
            accept(rdy);
            chk("t2_ready", rdy, exp_rdy);
            chk("t2_angle", cordic_angle, 22'h010000 * (i + 1));
            wait_rsp(cyc);
            chk("t2_id", rsp_id, i);
            step();
        end
        req_valid = 4'b1010;
        accept(rdy);
        chk("t2_ready_1", rdy, 4'b0010);
        wait_rsp(cyc);
        chk("t2_id_1", rsp_id, 1);
        step();
        accept(rdy);
        chk("t2_ready_3", rdy, 4'b1000);
        wait_rsp(cyc);
        chk("t2_id_3", rsp_id, 3);
        step();

        // timeout, then a normal job
        stub_en   = 1'b0;
        req_valid = 4'b0100;
        accept(rdy);
        chk("t3_ready", rdy, 4'b0100);
        wait_rsp(cyc);
        chk("t3_timeout_lat", cyc, TIMEOUT + 1);
        chk("t3_rsp", {rsp_id, rsp_cos, rsp_err}, {2'd2, 22'h000000, 1'b1});
        step();
        stub_en   = 1'b1;
        stub_lat  = 5;
        stub_cos  = 22'h0ABCDE;
        req_valid = 4'b0001;
        accept(rdy);
        chk("t3_next_ready", rdy, 4'b0001);
        wait_rsp(cyc);
        chk("t3_next_lat", cyc, 6);
        chk("t3_next_rsp", {rsp_id, rsp_cos, rsp_err}, {2'd0, 22'h0ABCDE, 1'b0});
        step();

        // done on the last watchdog cycle wins; done in first WAIT cycle
        stub_lat  = TIMEOUT;
        stub_cos  = 22'h033333;
        req_valid = 4'b0010;
        accept(rdy);
        wait_rsp(cyc);
        chk("t3_tie_lat", cyc, TIMEOUT + 1);
        chk("t3_tie_rsp", {rsp_id, rsp_cos, rsp_err}, {2'd1, 22'h033333, 1'b0});
        step();
        stub_lat  = 1;
        stub_cos  = 22'h3F0001;
        req_valid = 4'b0001;
        accept(rdy);
        chk("t3_fast_ready", rdy, 4'b0001);
        wait_rsp(cyc);
        chk("t3_fast_lat", cyc, 2);
        chk("t3_fast_rsp", {rsp_id, rsp_cos, rsp_err}, {2'd0, 22'h3F0001, 1'b0});
        step();

        // backpressure with request 2 pending
        rsp_ready = 1'b0;
        stub_lat  = 4;
        stub_cos  = 22'h012345;
        set_angle(1, 22'h020000);
        req_valid = 4'b0010;
        accept(rdy);
        chk("t4_ready", rdy, 4'b0010);
        wait_rsp(cyc);
        chk("t4_lat", cyc, 5);
        set_angle(2, 22'h030000);
        req_valid = 4'b0100;
        starts0   = n_starts;
        repeat (10) begin
            chk("t4_hold", {rsp_valid, rsp_id, rsp_cos, rsp_err, req_ready,
                            cordic_start, busy},
                {1'b1, 2'd1, 22'h012345, 1'b0, 4'b0000, 1'b0, 1'b1});
            step();
        end
        chk("t4_no_start", n_starts - starts0, 0);
        rsp_ready = 1'b1;
        step();
        accept(rdy);
        chk("t4_after_ready", rdy, 4'b0100);
        chk("t4_after_angle", cordic_angle, 22'h030000);
        wait_rsp(cyc);
        chk("t4_after_id", rsp_id, 2);
        step();

        // reset in WAIT, stale done must be ignored
        stub_lat  = 20;
        set_angle(3, 22'h3C0000);
        req_valid = 4'b1000;
        accept(rdy);
        chk("t5_ready", rdy, 4'b1000);
        repeat (5) step();
        chk("t5_in_wait", {busy, rsp_valid}, 2'b10);
        reset = 1'b0;
        step();
        chk("t5_reset_outs", {req_ready, rsp_valid, rsp_id, rsp_cos, rsp_err,
                              cordic_start, cordic_angle, busy}, '0);
        reset = 1'b1;
        n_rv  = 0;
        repeat (30) begin
            step();
            if (rsp_valid === 1'b1 || busy === 1'b1) n_rv++;
        end
        chk("t5_no_rsp", n_rv, 0);

        // angle stability after acceptance
        stub_lat = 10;
        stub_cos = 22'h0DDB3D;
        set_angle(0, 22'h100000);
        set_angle(1, 22'h2F0000);
        req_valid = 4'b0001;
        accept(rdy);
        chk("t6_ready", rdy, 4'b0001);
        set_angle(0, 22'h3FFFFF);
        req_valid = 4'b0010;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 200) begin
            chk("t6_angle", {cordic_angle, req_ready}, {22'h100000, 4'b0000});
            step();
            cyc++;
        end
        chk("t6_lat", cyc, 11);
        chk("t6_rsp", {rsp_id, rsp_cos, rsp_err}, {2'd0, 22'h0DDB3D, 1'b0});
        step();
        accept(rdy);
        chk("t6_next_ready", rdy, 4'b0010);
        chk("t6_next_angle", cordic_angle, 22'h2F0000);
        wait_rsp(cyc);
        chk("t6_next_id", rsp_id, 1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
